// File: rtl/muldiv_hilo_controller_if.sv
// Request/response bundle between the EX stage and the HI/LO mul/div sequencer.
// Cancel exists only when MULDIV_CANCEL_EN is defined.
interface muldiv_hilo_controller_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  Start;
  logic [1:0]            Op;
  logic [DATA_WIDTH-1:0] OperandA;
  logic [DATA_WIDTH-1:0] OperandB;
  logic                  ReadHiLo;
`ifdef MULDIV_CANCEL_EN
  logic                  Cancel;
`endif
  logic                  Busy;
  logic                  Stall;
  logic [DATA_WIDTH-1:0] Hi;
  logic [DATA_WIDTH-1:0] Lo;
  logic                  Done;
  logic                  DivByZero;

  modport master (
    output Start, Op, OperandA, OperandB, ReadHiLo,
`ifdef MULDIV_CANCEL_EN
    output Cancel,
`endif
    input  Busy, Stall, Hi, Lo, Done, DivByZero
  );

  modport slave (
    input  Start, Op, OperandA, OperandB, ReadHiLo,
`ifdef MULDIV_CANCEL_EN
    input  Cancel,
`endif
    output Busy, Stall, Hi, Lo, Done, DivByZero
  );
endinterface

// File: rtl/muldiv_hilo_controller.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO: radix-2 shift-add multiply, restoring divide.
// Optional flush input Cancel is enabled by defining MULDIV_CANCEL_EN.
module muldiv_hilo_controller #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] HILO_RESET = '0
) (
  input logic                     Clk,
  input logic                     Reset,
  muldiv_hilo_controller_if.slave bus
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          is_div, sign_a, sign_b;
  logic [W-1:0]  mag_a, mag_b, acc_hi, acc_lo;
  logic [W-1:0]  hi_q, lo_q;
  logic          done_q, dbz_q;
  logic          cancel;

`ifdef MULDIV_CANCEL_EN
  assign cancel = bus.Cancel;
`else
  assign cancel = 1'b0;
`endif

  // Operand capture: signed ops work on magnitudes, signs are reapplied in FIX
  logic         in_signed, in_sign_a, in_sign_b;
  logic [W-1:0] in_mag_a, in_mag_b;
  assign in_signed = ~bus.Op[0];
  assign in_sign_a = in_signed & bus.OperandA[W-1];
  assign in_sign_b = in_signed & bus.OperandB[W-1];
  assign in_mag_a  = in_sign_a ? -bus.OperandA : bus.OperandA;
  assign in_mag_b  = in_sign_b ? -bus.OperandB : bus.OperandB;

  // Multiply step: acc_lo holds the remaining multiplier bits, product shifts in from the top
  logic [W-1:0] addend;
  logic [W:0]   add_sum;
  assign addend  = acc_lo[0] ? mag_a : '0;
  assign add_sum = {1'b0, acc_hi} + {1'b0, addend};

  // Divide step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in
  logic [W:0] shifted, diff;
  logic       fits;
  assign shifted = {acc_hi, acc_lo[W-1]};
  assign diff    = shifted - {1'b0, mag_b};
  assign fits    = (shifted >= {1'b0, mag_b});

  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, raw_a;
  logic           div_zero;
  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = (sign_a ^ sign_b) ? -prod : prod;
  assign quo_fix  = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
  assign rem_fix  = sign_a ? -acc_hi : acc_hi;
  assign raw_a    = sign_a ? -mag_a : mag_a;
  assign div_zero = (mag_b == '0);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      count  <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_q   <= HILO_RESET;
      lo_q   <= HILO_RESET;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start && !cancel) begin
            is_div <= bus.Op[1];
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
            mag_a  <= in_mag_a;
            mag_b  <= in_mag_b;
            acc_hi <= '0;
            acc_lo <= bus.Op[1] ? in_mag_a : in_mag_b;
            count  <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            if (is_div) begin
              acc_hi <= fits ? diff[W-1:0] : shifted[W-1:0];
              acc_lo <= {acc_lo[W-2:0], fits};
            end else begin
              {acc_hi, acc_lo} <= {add_sum, acc_lo[W-1:1]};
            end
            if (count == CW'(W - 1)) state <= FIX;
            else                     count <= count + 1'b1;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!cancel) begin
            done_q <= 1'b1;
            if (is_div) begin
              if (div_zero) begin
                hi_q  <= raw_a;
                lo_q  <= '1;
                dbz_q <= 1'b1;
              end else begin
                hi_q <= rem_fix;
                lo_q <= quo_fix;
              end
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy      = (state == RUN) || (state == FIX);
  assign bus.Stall     = bus.Busy & (bus.ReadHiLo | bus.Start);
  assign bus.Hi        = hi_q;
  assign bus.Lo        = lo_q;
  assign bus.Done      = done_q;
  assign bus.DivByZero = dbz_q;
endmodule

// File: tb/tb_muldiv_hilo_controller.sv
// Directed plus randomized checks of muldiv_hilo_controller against a 64-bit arithmetic model.
// Cancel scenarios run only when MULDIV_CANCEL_EN is defined.
module tb_muldiv_hilo_controller;
  logic Clk = 1'b0;
  logic Reset;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] model_hi, model_lo;

  muldiv_hilo_controller_if #(.DATA_WIDTH(32)) bus ();

  muldiv_hilo_controller #(
    .DATA_WIDTH(32),
    .HILO_RESET(32'h0000_0000)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV signed division truncates toward zero
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
    longint      sa, sb, q, r;
    logic [63:0] p, ua, ub;
    dbz = 1'b0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    case (op)
      2'b00: begin p = sa * sb; {hi, lo} = p; end
      2'b01: begin p = ua * ub; {hi, lo} = p; end
      default: begin
        if (b == 32'h0) begin
          hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1;
        end else if (op == 2'b10) begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end else begin
          p = ua / ub; lo = p[31:0];
          p = ua % ub; hi = p[31:0];
        end
      end
    endcase
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    logic        ed;
    int          early;
    model(op, a, b, eh, el, ed);
    bus.Start = 1'b1; bus.Op = op; bus.OperandA = a; bus.OperandB = b;
    tick();  // edge 0
    bus.Start = 1'b0; bus.Op = 2'($urandom); bus.OperandA = $urandom; bus.OperandB = $urandom;
    check({tag, " busy"}, 64'(bus.Busy), 64'd1);
    early = 0;
    for (int e = 1; e <= 32; e++) begin
      tick();
      if (bus.Done) early++;
      if (e == 16) check({tag, " hi_hold"}, {bus.Hi, bus.Lo}, {model_hi, model_lo});
    end
    check({tag, " early_done"}, 64'(early), 64'd0);
    tick();  // edge 33
    check({tag, " done"}, 64'(bus.Done), 64'd1);
    check({tag, " hi"}, 64'(bus.Hi), 64'(eh));
    check({tag, " lo"}, 64'(bus.Lo), 64'(el));
    check({tag, " dbz"}, 64'(bus.DivByZero), 64'(ed));
    check({tag, " idle"}, 64'(bus.Busy), 64'd0);
    model_hi = eh; model_lo = el;
    tick();
    check({tag, " done_pulse"}, {62'd0, bus.Done, bus.DivByZero}, 64'd0);
  endtask

  initial begin
    logic [31:0] eh, el, eh2, el2, ra, rb;
    logic        ed;
    int          cnt;
    logic [1:0]  rop;
    Reset = 1'b1;
    bus.Start = 1'b0; bus.Op = 2'b00; bus.OperandA = '0; bus.OperandB = '0; bus.ReadHiLo = 1'b0;
`ifdef MULDIV_CANCEL_EN
    bus.Cancel = 1'b0;
`endif
    model_hi = 32'h0; model_lo = 32'h0;
    tick(); tick();
    check("reset busy_stall_done", {61'd0, bus.Busy, bus.Stall, bus.Done}, 64'd0);
    check("reset hilo", {bus.Hi, bus.Lo}, 64'd0);
    Reset = 1'b0;
    tick();

    run_op("mult_7x-3",    2'b00, 32'd7, 32'hFFFF_FFFD);
    run_op("multu_max",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_min_min", 2'b00, 32'h8000_0000, 32'h8000_0000);
    run_op("div_-7/2",     2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op("div_ovf",      2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_by0",     2'b11, 32'd7, 32'd0);
    run_op("div_by0_neg",  2'b10, 32'hFFFF_FF00, 32'd0);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'h0;
        1:       rb = $urandom_range(1, 20);
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op("random", rop, ra, rb);
    end

    // Reader and a back-to-back Start racing a running op
    model(2'b00, 32'd100, 32'd5, eh, el, ed);
    model(2'b11, 32'd1000, 32'd7, eh2, el2, ed);
    bus.Start = 1'b1; bus.Op = 2'b00; bus.OperandA = 32'd100; bus.OperandB = 32'd5;
    tick();  // edge 0
    bus.Start = 1'b0;
    tick(); tick();  // edges 1, 2
    bus.Start = 1'b1; bus.Op = 2'b11; bus.OperandA = 32'd1000; bus.OperandB = 32'd7;
    cnt = 0;
    for (int e = 3; e <= 32; e++) begin
      tick();
      if (e == 4) bus.ReadHiLo = 1'b1;
      if (!bus.Stall) cnt++;
    end
    check("race stall_held", 64'(cnt), 64'd0);
    tick();  // edge 33
    check("race done_stall", {62'd0, bus.Done, bus.Stall}, 64'd2);
    check("race new_lo", 64'(bus.Lo), 64'(el));
    check("race new_hi", 64'(bus.Hi), 64'(eh));
    bus.ReadHiLo = 1'b0;
    tick();  // edge 34: second op accepted
    check("race second_accept", {62'd0, bus.Busy, bus.Stall}, 64'd3);
    bus.Start = 1'b0;
    cnt = 0;
    for (int e = 35; e <= 66; e++) begin
      tick();
      if (bus.Done) cnt++;
    end
    check("race second_early", 64'(cnt), 64'd0);
    tick();  // edge 67
    check("race second_done", 64'(bus.Done), 64'd1);
    check("race second_hilo", {bus.Hi, bus.Lo}, {eh2, el2});
    model_hi = eh2; model_lo = el2;
    tick();

    // Async reset in the middle of RUN
    bus.Start = 1'b1; bus.Op = 2'b01; bus.OperandA = $urandom; bus.OperandB = $urandom;
    tick();
    bus.Start = 1'b0; bus.ReadHiLo = 1'b1;
    for (int e = 1; e <= 10; e++) tick();
    check("midrun stall", 64'(bus.Stall), 64'd1);
    #2 Reset = 1'b1;
    #1;
    check("midrun reset busy_stall", {62'd0, bus.Busy, bus.Stall}, 64'd0);
    check("midrun reset hilo", {bus.Hi, bus.Lo}, 64'd0);
    #2 Reset = 1'b0;
    bus.ReadHiLo = 1'b0;
    model_hi = 32'h0; model_lo = 32'h0;
    cnt = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (bus.Done || bus.Busy) cnt++;
    end
    check("midrun no_done", 64'(cnt), 64'd0);

    run_op("post_reset", 2'b00, 32'd12345, 32'hFFFF_FF85);

`ifdef MULDIV_CANCEL_EN
    bus.Start = 1'b1; bus.Op = 2'b10; bus.OperandA = 32'd999; bus.OperandB = 32'd4;
    tick();
    bus.Start = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    bus.Cancel = 1'b1;
    tick();  // edge 5
    check("cancel busy", 64'(bus.Busy), 64'd0);
    check("cancel hilo", {bus.Hi, bus.Lo}, {model_hi, model_lo});
    bus.Cancel = 1'b0;
    cnt = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (bus.Done) cnt++;
    end
    check("cancel no_done", 64'(cnt), 64'd0);
    bus.Cancel = 1'b1; bus.Start = 1'b1;
    tick();
    check("cancel start_ignored", 64'(bus.Busy), 64'd0);
    bus.Cancel = 1'b0; bus.Start = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
